// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared widths and arbiter state encoding for the pipeline
// Rev     : 1.0
// ============================================================================
package pipe_pkg;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_BUSY = 3'd1,
        F_RESP = 3'd2,
        D_BUSY = 3'd3,
        D_RESP = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones instead of wrapping
// Rev     : 1.0
// ============================================================================
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != C_MAX)) begin
            count_d = count_q + C_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Serialises IF and MEM-stage accesses onto one memory port
// Rev     : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW = pipe_pkg::AW,
    parameter int DW = pipe_pkg::DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          flush,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_fetch,
    output logic          stall_pipe,
    output logic [CW-1:0] stall_cnt
);

    import pipe_pkg::*;

    arb_state_t    state_q,     state_d;
    logic          drop_q,      drop_d;
    logic          last_d_q,    last_d_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // Data wins contention unless it also won the previous grant
                if (dm_req && (!if_req || !last_d_q)) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    last_d_d    = 1'b1;
                end else if (if_req) begin
                    state_d     = F_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    last_d_d    = 1'b0;
                end
            end
            F_BUSY: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = F_RESP;
                end
            end
            F_RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            D_BUSY: begin
                if (mem_ack) begin
                    dm_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = D_RESP;
                end
            end
            D_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_valid  = (state_q == F_RESP) && !drop_q && !flush;
    assign dm_valid  = (state_q == D_RESP);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls are gated by reset so the pipeline is released the moment reset hits
    assign stall_pipe  = !reset && dm_req && !dm_valid;
    assign stall_fetch = stall_pipe || (!reset && if_req && !if_valid);

    sat_counter #(
        .CW (CW)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_pipe),
        .count (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Randomised scoreboard bench for mem_arbiter (CW=4 instance)
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          flush = 1'b0;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          stall_fetch;
    logic          stall_pipe;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .flush       (flush),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_fetch (stall_fetch),
        .stall_pipe  (stall_pipe),
        .stall_cnt   (stall_cnt)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] rdata;
    } dm_item_t;

    logic [31:0] if_exp [$];
    dm_item_t    dm_exp [$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];

    int checks   = 0;
    int failures = 0;
    bit if_done  = 1'b0;
    bit dm_done  = 1'b0;
    bit hold_ack = 1'b0;
    bit timeout  = 1'b0;
    int if_wait  = 0;
    int dm_wait  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Initial memory contents: distinct value per word address
    function automatic logic [31:0] mhash(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h2008_0005;
    endfunction

    // Memory model: random 1..3 cycle ack latency, spurious acks while idle
    int lat = -1;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
                lat     = -1;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !hold_ack) begin
                if (lat < 0) lat = $urandom_range(0, 2);
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    lat     = -1;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mhash(mem_addr);
                    end
                end else begin
                    lat--;
                end
            end else if (!mem_req && !hold_ack && ($urandom_range(0, 7) == 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Reference: one access at a time, data-first with alternation under contention
    int          owner;   // 0 none, 1 fetch, 2 data
    bit          resp, squash, last_d;
    int          cnt;
    logic        g_we;
    logic [31:0] g_addr, g_wdata;
    bit          exp_iv, exp_dv, exp_sp, exp_sf;
    logic [31:0] e_addr;
    dm_item_t    e_item;

    initial begin
        owner = 0; resp = 0; squash = 0; last_d = 0; cnt = 0;
        g_we = 1'b0; g_addr = '0; g_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_mem_req",     32'(mem_req),     32'd0);
                chk("rst_if_valid",    32'(if_valid),    32'd0);
                chk("rst_dm_valid",    32'(dm_valid),    32'd0);
                chk("rst_stall_pipe",  32'(stall_pipe),  32'd0);
                chk("rst_stall_fetch", 32'(stall_fetch), 32'd0);
                chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
                chk("rst_mem_addr",    mem_addr,         32'd0);
                chk("rst_dm_rdata",    dm_rdata,         32'd0);
                owner = 0; resp = 0; squash = 0; last_d = 0; cnt = 0;
                if_exp.delete();
                dm_exp.delete();
                if_done = 1'b0;
                dm_done = 1'b0;
            end else begin
                exp_iv = resp && (owner == 1) && !squash && !flush;
                exp_dv = resp && (owner == 2);
                exp_sp = dm_req && !exp_dv;
                exp_sf = exp_sp || (if_req && !exp_iv);
                chk("mem_req",     32'(mem_req),     32'((owner != 0) && !resp));
                chk("if_valid",    32'(if_valid),    32'(exp_iv));
                chk("dm_valid",    32'(dm_valid),    32'(exp_dv));
                chk("stall_pipe",  32'(stall_pipe),  32'(exp_sp));
                chk("stall_fetch", 32'(stall_fetch), 32'(exp_sf));
                chk("stall_cnt",   32'(stall_cnt),   32'(cnt));
                if ((owner != 0) && !resp) begin
                    chk("mem_addr", mem_addr,    g_addr);
                    chk("mem_we",   32'(mem_we), 32'(g_we));
                    if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
                end
                if (if_valid) begin
                    if (if_exp.size() == 0) begin
                        chk("if_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e_addr = if_exp.pop_front();
                        chk("if_rdata", if_rdata, mhash(e_addr));
                    end
                    if_done = 1'b1;
                end
                if (dm_valid) begin
                    if (dm_exp.size() == 0) begin
                        chk("dm_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e_item = dm_exp.pop_front();
                        if (!e_item.we) chk("dm_rdata", dm_rdata, e_item.rdata);
                    end
                    dm_done = 1'b1;
                end
                if (exp_sp && (cnt < CNT_MAX)) cnt++;
                if (resp) begin
                    owner = 0; resp = 0; squash = 0;
                end else if (owner != 0) begin
                    if ((owner == 1) && flush) squash = 1;
                    if (mem_ack) resp = 1;
                end else if (dm_req && (!if_req || !last_d)) begin
                    owner = 2; last_d = 1;
                    g_we = dm_we; g_addr = dm_addr; g_wdata = dm_wdata;
                end else if (if_req) begin
                    owner = 1; last_d = 0;
                    g_we = 1'b0; g_addr = if_addr; g_wdata = '0;
                end
            end
        end
    end

    // One cycle of port stimulus; a flush redirects the PC to a different address
    task automatic drive_cycle(input bit allow_new);
        dm_item_t it;
        flush = 1'b0;
        if (if_done) begin
            if_req = 1'b0; if_done = 1'b0; if_wait = 0;
        end else if (if_req) begin
            if_wait++;
            if ($urandom_range(0, 11) == 0) begin
                flush   = 1'b1;
                if_addr = {20'd0, if_addr[11:2] + 10'($urandom_range(1, 1022)), 2'b00};
                if_exp[if_exp.size() - 1] = if_addr;
            end
        end else if (allow_new && ($urandom_range(0, 3) == 0)) begin
            if_req  = 1'b1;
            if_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if_exp.push_back(if_addr);
        end else if ($urandom_range(0, 15) == 0) begin
            flush = 1'b1;
        end
        if (dm_done) begin
            dm_req = 1'b0; dm_done = 1'b0; dm_wait = 0;
        end else if (dm_req) begin
            dm_wait++;
        end else if (allow_new && ($urandom_range(0, 3) == 0)) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            dm_wdata = $urandom;
            it.we    = dm_we;
            it.addr  = dm_addr;
            it.rdata = ref_mem.exists(dm_addr) ? ref_mem[dm_addr] : mhash(dm_addr);
            if (dm_we) ref_mem[dm_addr] = dm_wdata;
            dm_exp.push_back(it);
        end
        if ((if_wait > 100) || (dm_wait > 100)) timeout = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int c = 0; c < n && !timeout; c++) begin
            @(posedge clk);
            #1;
            drive_cycle(1'b1);
        end
        for (int c = 0; c < 100 && !timeout && (if_req || dm_req); c++) begin
            @(posedge clk);
            #1;
            drive_cycle(1'b0);
        end
        chk("req_timeout", 32'(timeout), 32'd0);
        chk("drain_idle",  32'({if_req, dm_req}), 32'd0);
    endtask

    initial begin
        dm_item_t it;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        random_phase(2000);

        if (!timeout) begin
            // Clear the counter, then hold a load with no ack for 20 cycles
            @(posedge clk); #1; reset = 1'b1;
            @(posedge clk); #1; reset = 1'b0;
            hold_ack = 1'b1;
            dm_req   = 1'b1;
            dm_we    = 1'b0;
            dm_addr  = 32'h0000_1100;
            it.we    = 1'b0;
            it.addr  = dm_addr;
            it.rdata = mhash(dm_addr);
            dm_exp.push_back(it);
            repeat (20) @(posedge clk);
            #1;
            chk("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
            chk("hold_mem_req",  32'(mem_req),   32'd1);

            // Reset in the middle of the outstanding data access
            reset = 1'b1;
            #1;
            chk("midrst_mem_req",    32'(mem_req),    32'd0);
            chk("midrst_stall_pipe", 32'(stall_pipe), 32'd0);
            chk("midrst_dm_valid",   32'(dm_valid),   32'd0);
            chk("midrst_stall_cnt",  32'(stall_cnt),  32'd0);
            @(posedge clk); #1;
            dm_req   = 1'b0;
            hold_ack = 1'b0;
            dm_wait  = 0;
            @(posedge clk); #1;
            reset = 1'b0;

            random_phase(400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port. It serialises accesses with a level request / one-cycle valid handshake and drives the pipeline freeze signals `stall_fetch` and `stall_pipe`. It also squashes wrong-path fetches on branch flush and keeps a saturating stall-cycle counter for debug. It sits between the `pipeline` top-level stages and the memory model.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `CW`, 16, stall counter width
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `if_req` in 1: fetch request, held until `if_valid`
- `if_addr` in AW: fetch address (PC)
- `if_rdata` out DW: fetched instruction; reset 0
- `if_valid` out 1: one-cycle fetch completion; reset 0
- `flush` in 1: branch/jump redirect; squashes an in-flight fetch
- `dm_req` in 1: data request, held until `dm_valid`
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in AW: data address
- `dm_wdata` in DW: store data
- `dm_rdata` out DW: load data; reset 0
- `dm_valid` out 1: one-cycle data completion; reset 0
- `mem_req` out 1: memory request, held until `mem_ack`; reset 0
- `mem_we` out 1: write enable; reset 0
- `mem_addr` out AW: memory address; reset 0
- `mem_wdata` out DW: memory write data; reset 0
- `mem_rdata` in DW: memory read data, valid with `mem_ack`
- `mem_ack` in 1: one-cycle completion from memory, arbitrary latency ≥1 cycle after `mem_req` rises
- `stall_fetch` out 1: freeze PC and IF/ID; reset 0
- `stall_pipe` out 1: freeze all pipeline registers; reset 0
- `stall_cnt` out CW: saturating count of cycles with `stall_pipe`=1; reset 0

## Operation
- FSM states:
  - IDLE
  - F_BUSY, F_RESP (fetch)
  - D_BUSY, D_RESP (data)
- One memory access is outstanding at a time.
- IDLE grant rule:
  - Only `dm_req` high → D_BUSY.
  - Only `if_req` high → F_BUSY.
  - Both high → data wins, unless the previous grant (`last_d`=1) was data; then fetch wins. This alternates grants under contention.
- Grant edge: register `mem_req`=1 and capture `mem_we`/`mem_addr`/`mem_wdata` from the winning port. Fetch grants always have `mem_we`=0.
- *_BUSY:
  - Hold `mem_*` stable.
  - On `mem_ack`: capture `mem_rdata` into `if_rdata`/`dm_rdata`, drop `mem_req`, go to *_RESP.
- *_RESP: lasts one cycle.
  - `if_valid` = (state==F_RESP) & ~drop & ~flush.
  - `dm_valid` = (state==D_RESP).
  - Next state is IDLE. No grant is made in a RESP cycle, so a request still held high during its valid cycle is never re-issued.
- Flush:
  - `flush` in F_BUSY sets `drop`; the access completes normally, but `if_valid` is suppressed and `drop` clears on leaving F_RESP.
  - `flush` in IDLE has no effect.
  - `flush` never affects data accesses.
- Stalls (combinational from state and inputs):
  - `stall_pipe` = `dm_req` & ~`dm_valid`.
  - `stall_fetch` = `stall_pipe` | (`if_req` & ~`if_valid`).
- `stall_cnt` increments on every cycle with `stall_pipe`=1 and saturates at 2^CW−1; it never wraps.
- Reset asserted at any time, including mid-access:
  - state→IDLE, `mem_req`→0 immediately, `drop`=0, `last_d`=0, all outputs 0.
  - The memory must tolerate an abandoned request.

## Timing
- Request seen high in IDLE at edge N → `mem_req`=1 after edge N.
- `mem_ack` in cycle M → *_valid high in cycle M+1 for exactly one cycle.
- Minimum access is 3 cycles, request to valid, with a 1-cycle `mem_ack`.
- Back-to-back same-port accesses issue no sooner than every (latency+2) cycles.
- Fetch and data both pending, `last_d`=0: data completes first, and the fetch issues on the first IDLE cycle after D_RESP.
- `mem_ack` outside *_BUSY is ignored.

## Structure
- Shared package `pipe_pkg` holds:
  - state enum `arb_state_t` {IDLE, F_BUSY, F_RESP, D_BUSY, D_RESP}
  - width constants AW/DW
- Sub-module `sat_counter` (parameter CW; inputs clk, reset, inc; output count) implements `stall_cnt`; it is reusable by other performance counters.
- Everything else lives in `mem_arbiter`.

## Test plan
- Lone fetch: `if_req`=1, `if_addr`=0x40, memory acks 2 cycles after `mem_req` with 0x20080005 → `mem_req` high for 2 cycles, `if_valid` pulse, `if_rdata`=0x20080005, `stall_pipe`=0 throughout.
- Load vs fetch contention: `dm_req`(load 0x100 → 0xDEADBEEF) and `if_req`(0x44) rise in the same cycle → data granted first, `dm_rdata`=0xDEADBEEF, then the fetch of 0x44. `stall_pipe` is high until `dm_valid`; `stall_fetch` is high until `if_valid`.
- Alternation: `dm_req` and `if_req` held high for 4 accesses → grant order D, F, D, F.
- Store: `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0x12345678 → `mem_we`=1 with the same addr/data held until `mem_ack`, then a `dm_valid` pulse.
- Flush: `flush` pulsed during F_BUSY for `if_addr`=0x48 → no `if_valid`, FSM returns to IDLE, the next fetch of 0x80 completes normally.
- Reset mid-access: assert `reset` during D_BUSY → `mem_req`, `stall_pipe`, and `dm_valid` drop immediately, `stall_cnt`=0. With CW=4 and a 20-cycle stall, `stall_cnt` saturates at 15.
